pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Combines load-use,
//  branch/jump redirect, data-memory wait and syscall-halt into per-stage enable/flush
//  controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Owns the RUN/MEMWAIT/HALT state
//  machine and the optional performance counters shown on the FPGA display.
// PARAMETERS
//  CNT_W          32  width of each performance counter
//  HALT_ON_RESET  0   1: leave reset in HALT (wait for go); 0: leave reset in RUN
// PORTS
//  clk           in   1      pipeline clock, single domain
//  rst_n         in   1      synchronous reset, active low
//  loaduse       in   1      load-use hazard on instruction in ID (from hazard detector)
//  branch_taken  in   1      beq/bne resolved taken in EX
//  jump_id       in   1      j/jal decoded in ID
//  halt_req      in   1      syscall halt committing in WB
//  go            in   1      resume level/button; rising edge detected internally
//  mem_req       in   1      MEM stage accesses data memory this cycle
//  mem_ready     in   1      data memory completes access this cycle
//  pc_en         out  1      PC register load enable
//  ifid_en       out  1      IF/ID enable
//  ifid_flush    out  1      IF/ID clear to bubble (nop)
//  idex_en       out  1      ID/EX enable
//  idex_flush    out  1      ID/EX clear to bubble
//  exmem_en      out  1      EX/MEM enable
//  memwb_en      out  1      MEM/WB enable
//  halted        out  1      1 while in HALT
//  cycle_cnt     out  CNT_W  cycles spent in RUN or MEMWAIT
//  stall_cnt     out  CNT_W  load-use bubble cycles
//  flush_cnt     out  CNT_W  redirect cycles (branch or jump)
//  memwait_cnt   out  CNT_W  cycles frozen on memory
// BEHAVIOUR
//  - States: RUN, MEMWAIT, HALT. Outputs combinational from state+inputs; state, go
//    edge register and counters registered on clk.
//  - Reset (rst_n=0 at posedge): state=HALT if HALT_ON_RESET else RUN; go_q=0;
//    counters=0. All outputs during reset: en=0, flush=0, halted=0, counters 0.
//  - Default in RUN: all *_en=1, all *_flush=0. Decision priority, first match wins:
//    1 halt_req: all en=0; next HALT (syscall already committed in WB).
//    2 mem_req&&!mem_ready: all en=0; next MEMWAIT.
//    3 branch_taken: pc_en=1, ifid_flush=1, idex_flush=1 (loaduse ignored: wrong path).
//    4 loaduse: pc_en=0, ifid_en=0, idex_flush=1 (one bubble; EX/MEM, MEM/WB advance).
//    5 jump_id: ifid_flush=1.
//  - Flush wins over en on the same register; flush inserts nop regardless of en.
//  - MEMWAIT: mem_ready=0 -> all en=0, stay. mem_ready=1 -> apply RUN rules 1,3,4,5
//    this cycle, next RUN. halt_req in MEMWAIT only honoured once mem_ready=1.
//  - HALT: all en=0, flush=0, halted=1. go rising edge (go && !go_q) -> next RUN;
//    go held high does not re-trigger; first RUN cycle applies default rules.
//  - Simultaneous halt_req and go edge in RUN: halt wins. Reset mid-MEMWAIT/HALT:
//    returns to reset state in one cycle, pending access abandoned.
//  - Counters: +1 per qualifying cycle, wrap modulo 2^CNT_W. stall_cnt counts rule 4
//    cycles only; flush_cnt counts rule 3 or 5 cycles (one per cycle, not per stage).
// CONFIGURATION
//  - PIPE_PERF_CNT_EN defined: four counters implemented as above.
//  - Undefined: no counter flops; cycle_cnt/stall_cnt/flush_cnt/memwait_cnt tied 0.
//    Control behaviour identical in both builds.
// STRUCTURE
//  - Shared header pipe_ctrl_defs.vh: state encodings ST_RUN=2'd0, ST_MEMWAIT=2'd1,
//    ST_HALT=2'd2; shared with the display/debug block that decodes state.
//  - One sub-module: pipe_perf_cnt (enable-gated wrapping counter, width CNT_W),
//    instantiated four times inside `ifdef PIPE_PERF_CNT_EN.
// TESTING
//  1 loaduse=1 one cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1; next cycle
//    defaults; stall_cnt 0->1.
//  2 branch_taken=1 with loaduse=1 -> pc_en=1, ifid_flush=1, idex_flush=1; stall_cnt
//    unchanged, flush_cnt +1.
//  3 mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles all en=0 (memwait_cnt=3),
//    4th cycle all en=1, state back to RUN.
//  4 halt_req=1 -> next cycle halted=1, all en=0; go held high 5 cycles -> exactly one
//    transition to RUN; go rising again while RUN has no effect.
//  5 HALT_ON_RESET=1, rst_n low 2 cycles -> halted=1 after release, counters 0 until go.
//  6 Build without PIPE_PERF_CNT_EN, rerun 1-3 -> identical control outputs, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: state encodings (also decoded
// by the display/debug block) and per-stage control bundles.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RUN    = 7'b110_1011;
  localparam stage_ctrl_t CTRL_FREEZE = 7'b000_0000;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard requests from the pipeline and the per-stage enable/flush controls back to it.
// master = pipeline datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if;
  logic loaduse;
  logic branch_taken;
  logic jump_id;
  logic halt_req;
  logic go;
  logic mem_req;
  logic mem_ready;
  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic idex_en;
  logic idex_flush;
  logic exmem_en;
  logic memwb_en;
  logic halted;

  modport master (
    output loaduse, branch_taken, jump_id, halt_req, go, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted
  );

  modport slave (
    input  loaduse, branch_taken, jump_id, halt_req, go, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Enable-gated wrapping performance counter with synchronous active-low reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_r;

  // count qualifying cycles, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (RUN/MEMWAIT/HALT).
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  memwait_cnt
);

  localparam pipe_state_e RESET_ST = HALT_ON_RESET ? ST_HALT : ST_RUN;

  pipe_state_e state_r;
  pipe_state_e state_nxt_s;
  logic        go_q_r;
  stage_ctrl_t ctrl_s;
  logic        halted_s;
  logic        stall_s;
  logic        redirect_s;
  logic        frozen_s;
  logic        active_s;

  // state register and go edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RESET_ST;
      go_q_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      go_q_r  <= hz.go;
    end
  end

  // next state and stage controls; a halt request waits for an outstanding access
  always_comb begin
    ctrl_s      = CTRL_RUN;
    halted_s    = 1'b0;
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    redirect_s  = 1'b0;
    frozen_s    = 1'b0;
    if (!rst_n) begin
      ctrl_s      = CTRL_FREEZE;
      state_nxt_s = RESET_ST;
    end else begin
      case (state_r)
        ST_HALT: begin
          ctrl_s   = CTRL_FREEZE;
          halted_s = 1'b1;
          if (hz.go && !go_q_r) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        ST_RUN, ST_MEMWAIT: begin
          if ((state_r == ST_MEMWAIT) && !hz.mem_ready) begin
            ctrl_s      = CTRL_FREEZE;
            frozen_s    = 1'b1;
            state_nxt_s = ST_MEMWAIT;
          end else if (hz.halt_req) begin
            ctrl_s      = CTRL_FREEZE;
            state_nxt_s = ST_HALT;
          end else if ((state_r == ST_RUN) && hz.mem_req && !hz.mem_ready) begin
            ctrl_s      = CTRL_FREEZE;
            frozen_s    = 1'b1;
            state_nxt_s = ST_MEMWAIT;
          end else if (hz.branch_taken) begin
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
            redirect_s        = 1'b1;
            state_nxt_s       = ST_RUN;
          end else if (hz.loaduse) begin
            ctrl_s.pc_en      = 1'b0;
            ctrl_s.ifid_en    = 1'b0;
            ctrl_s.idex_flush = 1'b1;
            stall_s           = 1'b1;
            state_nxt_s       = ST_RUN;
          end else if (hz.jump_id) begin
            ctrl_s.ifid_flush = 1'b1;
            redirect_s        = 1'b1;
            state_nxt_s       = ST_RUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        default: begin
          ctrl_s      = CTRL_FREEZE;
          state_nxt_s = RESET_ST;
        end
      endcase
    end
  end

  assign active_s = rst_n && ((state_r == ST_RUN) || (state_r == ST_MEMWAIT));

  assign hz.pc_en      = ctrl_s.pc_en;
  assign hz.ifid_en    = ctrl_s.ifid_en;
  assign hz.ifid_flush = ctrl_s.ifid_flush;
  assign hz.idex_en    = ctrl_s.idex_en;
  assign hz.idex_flush = ctrl_s.idex_flush;
  assign hz.exmem_en   = ctrl_s.exmem_en;
  assign hz.memwb_en   = ctrl_s.memwb_en;
  assign hz.halted     = halted_s;

`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk), .rst_n(rst_n), .en(active_s), .cnt(cycle_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .en(stall_s), .cnt(stall_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .en(redirect_s), .cnt(flush_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk(clk), .rst_n(rst_n), .en(frozen_s), .cnt(memwait_cnt)
  );
`else
  logic unused_perf_s;
  assign unused_perf_s = ^{active_s, stall_s, redirect_s, frozen_s};
  assign cycle_cnt     = {CNT_W{1'b0}};
  assign stall_cnt     = {CNT_W{1'b0}};
  assign flush_cnt     = {CNT_W{1'b0}};
  assign memwait_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors queue expected controls and
// counters; a negedge monitor pops and compares against the selected instance.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // input bits {loaduse, branch_taken, jump_id, halt_req, go, mem_req, mem_ready}
  localparam logic [6:0] I0 = 7'b0000000;
  localparam logic [6:0] LU = 7'b1000000;
  localparam logic [6:0] BR = 7'b0100000;
  localparam logic [6:0] JP = 7'b0010000;
  localparam logic [6:0] HR = 7'b0001000;
  localparam logic [6:0] GO = 7'b0000100;
  localparam logic [6:0] MQ = 7'b0000010;
  localparam logic [6:0] MR = 7'b0000001;

  // expected {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted}
  localparam logic [7:0] E_Z   = 8'b0000_0000;
  localparam logic [7:0] E_RUN = 8'b1101_0110;
  localparam logic [7:0] E_LU  = 8'b0001_1110;
  localparam logic [7:0] E_BR  = 8'b1111_1110;
  localparam logic [7:0] E_JP  = 8'b1111_0110;
  localparam logic [7:0] E_H   = 8'b0000_0001;

  typedef struct {
    bit          sel;
    logic [7:0]  ctrl;
    int unsigned cyc, stl, fl, mw;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  logic [31:0] cyc0, stl0, fl0, mw0, cyc1, stl1, fl1, mw1;
  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int vidx     = 0;

  pipe_hazard_ctrl_if hz0 ();
  pipe_hazard_ctrl_if hz1 ();

  pipe_hazard_ctrl #(.CNT_W(32), .HALT_ON_RESET(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .hz(hz0.slave),
    .cycle_cnt(cyc0), .stall_cnt(stl0), .flush_cnt(fl0), .memwait_cnt(mw0)
  );

  pipe_hazard_ctrl #(.CNT_W(32), .HALT_ON_RESET(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .hz(hz1.slave),
    .cycle_cnt(cyc1), .stall_cnt(stl1), .flush_cnt(fl1), .memwait_cnt(mw1)
  );

  always #5 clk = ~clk;

  task automatic drive(input bit sel, input bit rst, input logic [6:0] in,
                       input logic [7:0] ctrl, input int unsigned c, input int unsigned s,
                       input int unsigned f, input int unsigned m);
    exp_t e;
    @(posedge clk);
    #1;
    if (!sel) begin
      rst_n0 = rst;
      {hz0.loaduse, hz0.branch_taken, hz0.jump_id, hz0.halt_req, hz0.go,
       hz0.mem_req, hz0.mem_ready} = in;
    end else begin
      rst_n1 = rst;
      {hz1.loaduse, hz1.branch_taken, hz1.jump_id, hz1.halt_req, hz1.go,
       hz1.mem_req, hz1.mem_ready} = in;
    end
    e.sel  = sel;
    e.ctrl = ctrl;
    e.cyc  = PERF ? c : 0;
    e.stl  = PERF ? s : 0;
    e.fl   = PERF ? f : 0;
    e.mw   = PERF ? m : 0;
    e.idx  = vidx;
    q.push_back(e);
    vidx++;
  endtask

  // monitor: compare every presented cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      int unsigned gc, gs, gf, gm;
      e = q.pop_front();
      if (!e.sel) begin
        got = {hz0.pc_en, hz0.ifid_en, hz0.ifid_flush, hz0.idex_en, hz0.idex_flush,
               hz0.exmem_en, hz0.memwb_en, hz0.halted};
        gc = cyc0; gs = stl0; gf = fl0; gm = mw0;
      end else begin
        got = {hz1.pc_en, hz1.ifid_en, hz1.ifid_flush, hz1.idex_en, hz1.idex_flush,
               hz1.exmem_en, hz1.memwb_en, hz1.halted};
        gc = cyc1; gs = stl1; gf = fl1; gm = mw1;
      end
      n_checks++;
      if (got !== e.ctrl) begin
        n_fail++;
        $display("FAIL ctrl dut%0d v%0d: got %b want %b", e.sel, e.idx, got, e.ctrl);
      end
      n_checks++;
      if ({gc, gs, gf, gm} !== {e.cyc, e.stl, e.fl, e.mw}) begin
        n_fail++;
        $display("FAIL cnt dut%0d v%0d: got cyc=%0d stl=%0d fl=%0d mw=%0d want cyc=%0d stl=%0d fl=%0d mw=%0d",
                 e.sel, e.idx, gc, gs, gf, gm, e.cyc, e.stl, e.fl, e.mw);
      end
    end
  end

  initial begin
    rst_n0 = 1'b0;
    rst_n1 = 1'b0;
    {hz0.loaduse, hz0.branch_taken, hz0.jump_id, hz0.halt_req, hz0.go,
     hz0.mem_req, hz0.mem_ready} = I0;
    {hz1.loaduse, hz1.branch_taken, hz1.jump_id, hz1.halt_req, hz1.go,
     hz1.mem_req, hz1.mem_ready} = I0;
    repeat (2) @(posedge clk);

    // instance 0: leaves reset in RUN
    drive(0, 0, I0,           E_Z,    0, 0, 0, 0);
    drive(0, 1, I0,           E_RUN,  0, 0, 0, 0);
    drive(0, 1, LU,           E_LU,   1, 0, 0, 0);
    drive(0, 1, I0,           E_RUN,  2, 1, 0, 0);
    drive(0, 1, LU | BR,      E_BR,   3, 1, 0, 0);
    drive(0, 1, I0,           E_RUN,  4, 1, 1, 0);
    drive(0, 1, JP,           E_JP,   5, 1, 1, 0);
    drive(0, 1, MQ,           E_Z,    6, 1, 2, 0);
    drive(0, 1, MQ,           E_Z,    7, 1, 2, 1);
    drive(0, 1, MQ,           E_Z,    8, 1, 2, 2);
    drive(0, 1, MQ | MR,      E_RUN,  9, 1, 2, 3);
    drive(0, 1, I0,           E_RUN, 10, 1, 2, 3);
    drive(0, 1, MQ,           E_Z,   11, 1, 2, 3);
    drive(0, 1, HR,           E_Z,   12, 1, 2, 4);
    drive(0, 1, HR | MQ | MR | LU, E_Z, 13, 1, 2, 5);
    drive(0, 1, I0,           E_H,   14, 1, 2, 5);
    drive(0, 1, GO,           E_H,   14, 1, 2, 5);
    drive(0, 1, GO,           E_RUN, 14, 1, 2, 5);
    drive(0, 1, GO | HR,      E_Z,   15, 1, 2, 5);
    drive(0, 1, GO,           E_H,   16, 1, 2, 5);
    drive(0, 1, GO,           E_H,   16, 1, 2, 5);
    drive(0, 1, I0,           E_H,   16, 1, 2, 5);
    drive(0, 1, GO,           E_H,   16, 1, 2, 5);
    drive(0, 1, GO | JP,      E_JP,  16, 1, 2, 5);
    drive(0, 1, I0,           E_RUN, 17, 1, 3, 5);
    drive(0, 1, GO,           E_RUN, 18, 1, 3, 5);
    drive(0, 1, I0,           E_RUN, 19, 1, 3, 5);
    drive(0, 1, GO | HR,      E_Z,   20, 1, 3, 5);
    drive(0, 1, I0,           E_H,   21, 1, 3, 5);
    drive(0, 0, I0,           E_Z,   21, 1, 3, 5);
    drive(0, 1, I0,           E_RUN,  0, 0, 0, 0);
    drive(0, 1, MQ,           E_Z,    1, 0, 0, 0);
    drive(0, 0, MQ,           E_Z,    2, 0, 0, 1);
    drive(0, 1, I0,           E_RUN,  0, 0, 0, 0);
    drive(0, 1, I0,           E_RUN,  1, 0, 0, 0);
    drive(0, 1, MQ,           E_Z,    2, 0, 0, 0);
    drive(0, 1, BR | LU | MR, E_BR,   3, 0, 0, 1);
    drive(0, 1, I0,           E_RUN,  4, 0, 1, 1);

    // instance 1: leaves reset in HALT and waits for a go edge
    drive(1, 0, I0,           E_Z,    0, 0, 0, 0);
    drive(1, 1, I0,           E_H,    0, 0, 0, 0);
    drive(1, 1, I0,           E_H,    0, 0, 0, 0);
    drive(1, 1, GO,           E_H,    0, 0, 0, 0);
    drive(1, 1, I0,           E_RUN,  0, 0, 0, 0);
    drive(1, 1, I0,           E_RUN,  1, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
